// File: rtl/fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register. It keeps one imem
// request in flight and parks a returned instruction in a buffer while decode stalls.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PC_Write,
    input  logic            IF_ID_Write,
    input  logic            flush,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_instr,
    output logic            IF_ID_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        BUF   = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] buf_r;

    logic            advance_s;
    logic            deliver_s;
    logic [XLEN-1:0] deliver_data_s;
    logic [XLEN-1:0] pc_plus4_s;

    assign advance_s      = PC_Write & IF_ID_Write;
    assign pc_plus4_s     = pc_r + 32'd4;
    // A flush in the same cycle always wins over delivering an instruction.
    assign deliver_s      = ~flush & advance_s &
                            (((state_r == WAIT) & imem_rvalid) | (state_r == BUF));
    assign deliver_data_s = (state_r == BUF) ? buf_r : imem_rdata;

    assign imem_req  = (state_r == FETCH) & ~flush & ~reset;
    assign imem_addr = pc_r;

    // Fetch FSM: PC, outstanding-request tracking and the stall buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FETCH;
            pc_r    <= RESET_PC;
            buf_r   <= '0;
        end else begin
            case (state_r)
                FETCH: begin
                    if (flush) begin
                        pc_r <= redirect_pc;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && flush) begin
                        pc_r    <= redirect_pc;
                        state_r <= FETCH;
                    end else if (imem_rvalid && advance_s) begin
                        pc_r    <= pc_plus4_s;
                        state_r <= FETCH;
                    end else if (imem_rvalid) begin
                        buf_r   <= imem_rdata;
                        state_r <= BUF;
                    end else if (flush) begin
                        // Response still in flight: it must be swallowed when it arrives.
                        pc_r    <= redirect_pc;
                        state_r <= DROP;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                BUF: begin
                    if (flush) begin
                        buf_r   <= '0;
                        pc_r    <= redirect_pc;
                        state_r <= FETCH;
                    end else if (advance_s) begin
                        pc_r    <= pc_plus4_s;
                        state_r <= FETCH;
                    end else begin
                        state_r <= BUF;
                    end
                end
                DROP: begin
                    if (flush) begin
                        pc_r <= redirect_pc;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (imem_rvalid) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= DROP;
                    end
                end
                default: begin
                    state_r <= FETCH;
                end
            endcase
        end
    end

    // IF/ID pipeline register: flush beats stall, stall beats delivery.
    always_ff @(posedge clk) begin
        if (reset) begin
            IF_ID_pc    <= '0;
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (flush) begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end else if (!IF_ID_Write) begin
            IF_ID_pc    <= IF_ID_pc;
            IF_ID_instr <= IF_ID_instr;
            IF_ID_valid <= IF_ID_valid;
        end else if (deliver_s) begin
            IF_ID_pc    <= pc_r;
            IF_ID_instr <= deliver_data_s;
            IF_ID_valid <= 1'b1;
        end else begin
            IF_ID_instr <= NOP_INSTR;
            IF_ID_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responses are driven by hand, one cycle per step.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_Write;
    logic        IF_ID_Write;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .PC_Write    (PC_Write),
        .IF_ID_Write (IF_ID_Write),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .IF_ID_pc    (IF_ID_pc),
        .IF_ID_instr (IF_ID_instr),
        .IF_ID_valid (IF_ID_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic valid);
        chk({tag, "_pc"}, IF_ID_pc, pc);
        chk({tag, "_instr"}, IF_ID_instr, instr);
        chk({tag, "_valid"}, {31'd0, IF_ID_valid}, {31'd0, valid});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
        if (req) chk({tag, "_addr"}, imem_addr, addr);
    endtask

    initial begin
        reset = 1'b1; PC_Write = 1'b1; IF_ID_Write = 1'b1; flush = 1'b0;
        redirect_pc = 32'd0; imem_rvalid = 1'b0; imem_rdata = 32'd0;

        // Reset
        #1;
        chk_req("rst_req", 1'b0, 32'd0);
        tick(); tick();
        chk_ifid("rst", 32'd0, NOP, 1'b0);
        reset = 1'b0; #1;

        // Sequential fetch with 1-cycle memory, rdata = addr | 0x13
        chk_req("seq0", 1'b1, 32'h0);
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'h13; #1;
        chk_req("seq0w", 1'b0, 32'd0);
        chk_ifid("seq0w", 32'd0, NOP, 1'b0);
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("seq0d", 32'h0, 32'h13, 1'b1);
        chk_req("seq4", 1'b1, 32'h4);
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'h17; #1;
        chk_ifid("seq_bub", 32'h0, NOP, 1'b0);
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("seq4d", 32'h4, 32'h17, 1'b1);
        chk_req("seq8", 1'b1, 32'h8);
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'h1B; #1;
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("seq8d", 32'h8, 32'h1B, 1'b1);

        // Stall while the response arrives: buffer it, hold IF/ID, no new request
        PC_Write = 1'b0; IF_ID_Write = 1'b0; #1;
        chk_req("stall_req12", 1'b1, 32'hC);
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'h1F; #1;
        chk_ifid("stall1", 32'h8, 32'h1B, 1'b1);
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("stall2", 32'h8, 32'h1B, 1'b1);
        chk_req("stall2", 1'b0, 32'd0);
        tick(); #1;
        chk_ifid("stall3", 32'h8, 32'h1B, 1'b1);
        chk_req("stall3", 1'b0, 32'd0);
        tick(); PC_Write = 1'b1; IF_ID_Write = 1'b1; #1;
        chk_ifid("stall4", 32'h8, 32'h1B, 1'b1);
        chk_req("stall4", 1'b0, 32'd0);
        tick(); #1;
        chk_ifid("buf_out", 32'hC, 32'h1F, 1'b1);
        chk_req("after_buf", 1'b1, 32'h10);

        // Flush while waiting on a slow response: drop it, refetch at 0x100
        tick(); flush = 1'b1; redirect_pc = 32'h100; #1;
        chk_req("drop_flush", 1'b0, 32'd0);
        tick(); flush = 1'b0; #1;
        chk_ifid("drop1", 32'hC, NOP, 1'b0);
        chk_req("drop1", 1'b0, 32'd0);
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_0023; #1;
        chk_req("drop2", 1'b0, 32'd0);
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("drop3", 32'hC, NOP, 1'b0);
        chk_req("redir100", 1'b1, 32'h100);

        // Flush coincident with rvalid: rdata never reaches IF/ID
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_0013; flush = 1'b1;
        redirect_pc = 32'h200; #1;
        tick(); imem_rvalid = 1'b0; flush = 1'b0; #1;
        chk_ifid("fl_rv", 32'hC, NOP, 1'b0);
        chk_req("redir200", 1'b1, 32'h200);

        // Flush overrides IF_ID_Write=0 on a valid IF/ID entry
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'h213; #1;
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("d200", 32'h200, 32'h213, 1'b1);
        IF_ID_Write = 1'b0; flush = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        chk_req("fl_hold", 1'b0, 32'd0);
        tick(); flush = 1'b0; IF_ID_Write = 1'b1; #1;
        chk_ifid("fl_hold", 32'h200, 32'h0000_0013, 1'b0);
        chk_req("top_addr", 1'b1, 32'hFFFF_FFFC);

        // PC wrap-around at the top of the address space
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'hFFFF_FFFF; #1;
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFF, 1'b1);
        chk_req("wrap", 1'b1, 32'h0);

        // Reset with a request outstanding, then a stray rvalid
        tick(); reset = 1'b1; #1;
        chk_req("rst_wait", 1'b0, 32'd0);
        tick(); reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0055; #1;
        chk_ifid("rst_mid", 32'd0, NOP, 1'b0);
        chk_req("rst_first", 1'b1, 32'h0);
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("stray", 32'd0, NOP, 1'b0);
        chk_req("stray", 1'b0, 32'd0);
        tick(); imem_rvalid = 1'b1; imem_rdata = 32'h0000_0093; #1;
        tick(); imem_rvalid = 1'b0; #1;
        chk_ifid("post_rst", 32'h0, 32'h0000_0093, 1'b1);
        chk_req("post_rst", 1'b1, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I pipeline. It sits directly upstream of the hazard detection unit. It owns the PC and fetches from instruction memory over a single-outstanding request/response interface. It drives IF_ID_pc, IF_ID_instr and IF_ID_valid into decode, and it consumes PC_Write and IF_ID_Write from the hazard unit and flush/redirect from the branch resolution logic in EX.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h00000000, PC value after reset
NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
PC_Write  input  1  from hazard unit; 0 = freeze PC
IF_ID_Write  input  1  from hazard unit; 0 = hold IF/ID register
flush  input  1  taken branch/jump resolved in EX; kill wrong-path fetch
redirect_pc  input  XLEN  new PC, valid when flush=1
imem_req  output  1  fetch request strobe, one cycle per request
imem_addr  output  XLEN  fetch address, valid when imem_req=1
imem_rvalid  input  1  instruction return strobe
imem_rdata  input  XLEN  returned instruction, valid when imem_rvalid=1
IF_ID_pc  output  XLEN  PC of the instruction in the IF/ID register
IF_ID_instr  output  XLEN  instruction in the IF/ID register
IF_ID_valid  output  1  1 = IF/ID holds a real instruction, 0 = bubble

Behaviour:
- One clock (clk); reset is synchronous and active-high. When reset=1 at a rising edge: pc<=RESET_PC, state<=FETCH, IF_ID_pc<=0, IF_ID_instr<=NOP_INSTR, IF_ID_valid<=0, buffer cleared. imem_req=0 while reset=1.
- advance = PC_Write & IF_ID_Write. An instruction is delivered into IF/ID only when advance=1.
- At most one outstanding imem request. imem_rvalid arrives at least 1 cycle after the request. imem_rvalid with no outstanding request is ignored.
- States: FETCH, WAIT, BUF, DROP.
- FETCH state:
  - flush=0: imem_req=1 and imem_addr=pc (combinational); next state WAIT.
  - flush=1: imem_req=0, pc<=redirect_pc, stay in FETCH.
- WAIT state (imem_req=0):
  - rvalid & flush: discard rdata, pc<=redirect_pc, go to FETCH.
  - rvalid & advance: IF_ID_instr<=rdata, IF_ID_pc<=pc, IF_ID_valid<=1, pc<=pc+4, go to FETCH.
  - rvalid & !advance: capture rdata in the internal buffer, go to BUF.
  - flush & !rvalid: pc<=redirect_pc, go to DROP.
- BUF state:
  - flush: discard buffer, pc<=redirect_pc, go to FETCH.
  - advance: load buffer into IF/ID (valid=1, pc=pc), pc<=pc+4, go to FETCH.
  - otherwise hold.
- DROP state: wait for rvalid, discard it, go to FETCH.
  - flush while in DROP: pc<=redirect_pc, stay in DROP.
  - flush in the same cycle as rvalid: pc<=redirect_pc, go to FETCH.
- IF/ID register update, in priority order:
  1. flush=1: IF_ID_instr<=NOP_INSTR, IF_ID_valid<=0, IF_ID_pc unchanged. Flush overrides IF_ID_Write=0.
  2. IF_ID_Write=0: hold all IF/ID outputs.
  3. Delivery this cycle: load as described above.
  4. Otherwise: bubble, IF_ID_instr<=NOP_INSTR, IF_ID_valid<=0, IF_ID_pc held.
- PC arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFFFFFC wraps to 0. redirect_pc is taken as-is with no alignment check.
- Latency: rvalid in cycle t means IF_ID_valid=1 in cycle t+1. With 1-cycle memory, peak throughput is 1 instruction per 2 cycles.
- Reset mid-operation (any state, outstanding request included): returns to the reset values. A late rvalid after reset is ignored because state is FETCH.

Test Plan:
- Reset, then 1-cycle memory returning rdata=addr|0x13 -> imem_addr sequence 0,4,8; IF_ID_pc 0,4,8 with IF_ID_valid=1 every other cycle and bubbles (NOP_INSTR, valid=0) between.
- rvalid with PC_Write=IF_ID_Write=0 for 3 cycles, then released -> IF/ID holds the previous instruction for those 3 cycles; buffered instruction appears in IF/ID on the release edge+1; no new imem_req until then.
- flush=1, redirect_pc=0x100 while in WAIT with 3-cycle memory latency -> the returned instruction is dropped, IF_ID_valid=0, next imem_addr=0x100.
- flush and rvalid in the same cycle -> rdata is never visible in IF/ID; the next cycle issues imem_req at redirect_pc.
- flush with IF_ID_Write=0 and IF_ID_valid=1 -> IF_ID_instr=0x00000013 and IF_ID_valid=0 on the next edge.
- pc=0xFFFFFFFC delivered -> next imem_addr=0x00000000. reset asserted in WAIT, then a stray rvalid -> ignored, first post-reset imem_addr=RESET_PC.
